// File: rtl/universal_shift_register_param.sv
// universal_shift_register_param: falling-edge universal shift register with word capture and overrun flag; SHIFT_REG_PARITY_EN adds Word_Parity_Out
module universal_shift_register_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             Clk_In,
    input  logic             Reset_N_In,
    input  logic [1:0]       Mode_In,
    input  logic             Serial_Data_In,
    input  logic [WIDTH-1:0] Parallel_Data_In,
    output logic [WIDTH-1:0] Shift_Register,
    output logic             Serial_Data_Out,
    output logic [WIDTH-1:0] Word_Data_Out,
    output logic             Word_Valid_Out,
    input  logic             Word_Ready_In,
    output logic             Overrun_Out,
`ifdef SHIFT_REG_PARITY_EN
    output logic             Word_Parity_Out,
`endif
    input  logic             Clear_Overrun_In
);
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d, word_q, word_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d, ovr_q, ovr_d;
    logic             shift, done, accept, lost;

    // next register value, word completion and hand-off decisions
    always_comb begin
        shift   = (Mode_In == MODE_RIGHT) || (Mode_In == MODE_LEFT);
        sr_d    = (Mode_In == MODE_RIGHT) ? {Serial_Data_In, sr_q[WIDTH-1:1]} :
                  (Mode_In == MODE_LEFT)  ? {sr_q[WIDTH-2:0], Serial_Data_In} :
                  (Mode_In == MODE_LOAD)  ? Parallel_Data_In : sr_q;
        done    = shift && (cnt_q == CNT_LAST);
        cnt_d   = (Mode_In == MODE_LOAD) ? '0 :
                  !shift ? cnt_q :
                  done ? '0 : cnt_q + CNT_W'(1);
        accept  = done && (!valid_q || Word_Ready_In);
        lost    = done && valid_q && !Word_Ready_In;
        word_d  = accept ? sr_d : word_q;
        valid_d = accept ? 1'b1 : (valid_q && Word_Ready_In) ? 1'b0 : valid_q;
        ovr_d   = lost ? 1'b1 : Clear_Overrun_In ? 1'b0 : ovr_q;
    end

    // all state advances on the falling clock edge
    always_ff @(negedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SHIFT_REG_PARITY_EN
    logic parity_q;

    // parity follows the captured word and holds with it
    always_ff @(negedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) parity_q <= 1'b0;
        else parity_q <= accept ? ^sr_d : parity_q;
    end

    assign Word_Parity_Out = parity_q;
`endif

    assign Shift_Register  = sr_q;
    assign Serial_Data_Out = (Mode_In == MODE_LEFT) ? sr_q[WIDTH-1] : sr_q[0];
    assign Word_Data_Out   = word_q;
    assign Word_Valid_Out  = valid_q;
    assign Overrun_Out     = ovr_q;
endmodule

// File: tb/tb_universal_shift_register_param.sv
// tb_universal_shift_register_param: directed vector table plus corner-case sequences for WIDTH=8
module tb_universal_shift_register_param;
    logic       clk = 1'b1;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       sin = 1'b0;
    logic [7:0] pdata = 8'h00;
    logic       rdy = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] sr, word;
    logic       sout, valid, ovr;
`ifdef SHIFT_REG_PARITY_EN
    logic       parity;
`endif

    int total = 0;
    int bad = 0;

    universal_shift_register_param #(.WIDTH(8)) dut (
        .Clk_In(clk),
        .Reset_N_In(rst_n),
        .Mode_In(mode),
        .Serial_Data_In(sin),
        .Parallel_Data_In(pdata),
        .Shift_Register(sr),
        .Serial_Data_Out(sout),
        .Word_Data_Out(word),
        .Word_Valid_Out(valid),
        .Word_Ready_In(rdy),
        .Overrun_Out(ovr),
`ifdef SHIFT_REG_PARITY_EN
        .Word_Parity_Out(parity),
`endif
        .Clear_Overrun_In(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m;
        logic       s;
        logic [7:0] p;
        logic       r;
        logic       c;
        logic [7:0] sr;
        logic       v;
        logic [7:0] w;
        logic       o;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] m, input logic s, input logic [7:0] p, input logic r, input logic c);
        mode = m;
        sin = s;
        pdata = p;
        rdy = r;
        clr = c;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        rst_n = 1'b1;
        mode = 2'b00;
        rdy = 1'b0;
        clr = 1'b0;
    endtask

    // mode 10 feeds val MSB first, mode 01 feeds LSB first; either way the register ends equal to val
    task automatic shift_word(input logic [1:0] m, input logic [7:0] val, input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++)
            step(m, (m == 2'b10) ? val[7-i] : val[i], 8'h00, (i == 7) ? rdy_last : 1'b0, (i == 7) ? clr_last : 1'b0);
        rdy = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{2'd3, 1'b0, 8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b0};
        tbl[2]  = '{2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 8'h97, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 8'h2F, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{2'd0, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h2F, 1'b0, 8'h00, 1'b0};
        tbl[5]  = '{2'd3, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6]  = '{2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h80, 1'b0, 8'h00, 1'b0};
        tbl[7]  = '{2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h40, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hA0, 1'b0, 8'h00, 1'b0};
        tbl[9]  = '{2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hD0, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h68, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h34, 1'b0, 8'h00, 1'b0};
        tbl[12] = '{2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 8'h9A, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h4D, 1'b1, 8'h4D, 1'b0};
        tbl[14] = '{2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h4D, 1'b0, 8'h4D, 1'b0};
        tbl[15] = '{2'd0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h4D, 1'b0, 8'h4D, 1'b0};

        #2;
        chk("reset_sr", sr, 8'h00);
        chk("reset_word", word, 8'h00);
        chk("reset_valid", valid, 1'b0);
        chk("reset_ovr", ovr, 1'b0);
        @(posedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].m, tbl[i].s, tbl[i].p, tbl[i].r, tbl[i].c);
            chk($sformatf("vec%0d_sr", i), sr, tbl[i].sr);
            chk($sformatf("vec%0d_sout", i), sout, (tbl[i].m == 2'd2) ? tbl[i].sr[7] : tbl[i].sr[0]);
            chk($sformatf("vec%0d_valid", i), valid, tbl[i].v);
            chk($sformatf("vec%0d_word", i), word, tbl[i].w);
            chk($sformatf("vec%0d_ovr", i), ovr, tbl[i].o);
        end
`ifdef SHIFT_REG_PARITY_EN
        chk("parity_4d", parity, 1'b0);
`endif

        // back-to-back words without ready: first retained, overrun set, clear loses to a new overrun
        do_reset();
        shift_word(2'b10, 8'hC3, 1'b0, 1'b0);
        chk("w1_word", word, 8'hC3);
        chk("w1_valid", valid, 1'b1);
        chk("w1_ovr", ovr, 1'b0);
        shift_word(2'b10, 8'h3C, 1'b0, 1'b0);
        chk("w2_sr", sr, 8'h3C);
        chk("w2_word_kept", word, 8'hC3);
        chk("w2_ovr", ovr, 1'b1);
        shift_word(2'b01, 8'h55, 1'b0, 1'b1);
        chk("w3_sr", sr, 8'h55);
        chk("w3_ovr_priority", ovr, 1'b1);
        chk("w3_word_kept", word, 8'hC3);
        step(2'b00, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovr_cleared", ovr, 1'b0);
        chk("ovr_clr_valid", valid, 1'b1);

        // ready on the completing edge replaces the pending word
        do_reset();
        shift_word(2'b01, 8'h12, 1'b0, 1'b0);
        chk("rc1_word", word, 8'h12);
        shift_word(2'b10, 8'h34, 1'b1, 1'b0);
        chk("rc2_word", word, 8'h34);
        chk("rc2_valid", valid, 1'b1);
        chk("rc2_ovr", ovr, 1'b0);
`ifdef SHIFT_REG_PARITY_EN
        step(2'b00, 1'b0, 8'h00, 1'b1, 1'b0);
        shift_word(2'b10, 8'h4C, 1'b0, 1'b0);
        chk("parity_4c_word", word, 8'h4C);
        chk("parity_4c", parity, 1'b1);
`endif

        // asynchronous reset mid-word discards the partial word
        do_reset();
        shift_word(2'b01, 8'hFF, 1'b0, 1'b0);
        shift_word(2'b10, 8'h00, 1'b0, 1'b0);
        chk("pre_rst_ovr", ovr, 1'b1);
        for (int i = 0; i < 5; i++) step(2'b01, 1'b1, 8'h00, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sr", sr, 8'h00);
        chk("async_rst_word", word, 8'h00);
        chk("async_rst_valid", valid, 1'b0);
        chk("async_rst_ovr", ovr, 1'b0);
        @(posedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) step(2'b01, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_rst_7_valid", valid, 1'b0);
        step(2'b01, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_rst_8_valid", valid, 1'b1);
        chk("post_rst_8_word", word, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
